// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for param_sync_fifo: default sizes, FWFT mode constants,
// the occupancy-counter width function and the pointer wrap helper.
package param_sync_fifo_pkg;

    localparam int unsigned DEF_DWIDTH = 16;
    localparam int unsigned DEF_DEPTH  = 8;

    // Read-port modes
    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Width needed to hold an occupancy of 0..depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return 32'($clog2(depth + 32'd1));
    endfunction

    // Next pointer value; wraps from depth-1 to 0 by compare so any depth works
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Modulo-DEPTH pointer with count enable and synchronous clear.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - synchronous clear to zero (priority over en)
//   en         - advance pointer by one, wrapping DEPTH-1 -> 0
//   value      - registered pointer value
module fifo_wrap_ctr
    import param_sync_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(DEPTH)-1:0] value
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= AW'(wrap_inc(32'(value), DEPTH));
        end
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered status flags, sticky
// overflow/underflow, synchronous flush and a selectable read mode
// (registered read with one-cycle latency, or first-word-fall-through).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   clr               - synchronous flush (priority over wr_en/rd_en)
//   wr_en, din        - write request and data
//   rd_en             - read request (pop in FWFT mode)
//   dout, dout_valid  - read data and its qualifier
//   full, empty       - occupancy == DEPTH / occupancy == 0
//   almost_full       - occupancy >= AF_LEVEL
//   almost_empty      - occupancy <= AE_LEVEL
//   count             - current occupancy
//   overflow          - sticky: write attempted while full
//   underflow         - sticky: read attempted while empty
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH   = DEF_DWIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = FWFT_OFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [DWIDTH-1:0]            din,
    input  logic                         rd_en,
    output logic [DWIDTH-1:0]            dout,
    output logic                         dout_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Accept decisions use the registered flags; a flush cancels both
    assign wr_acc = wr_en && !full  && !clr;
    assign rd_acc = rd_en && !empty && !clr;

    // Head pointer after this edge, used to pre-fetch the FWFT output word
    assign rptr_nxt = rd_acc ? AW'(wrap_inc(32'(rptr), DEPTH)) : rptr;

    fifo_wrap_ctr #(.DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (wr_acc),
        .value (wptr)
    );

    fifo_wrap_ctr #(.DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (rd_acc),
        .value (rptr)
    );

    // Next occupancy
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= din;
        end
    end

    // Occupancy, status and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= !clr && (overflow  || (wr_en && full));
            underflow    <= !clr && (underflow || (rd_en && empty));
        end
    end

    // Read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clr) begin
            dout_valid <= 1'b0;
        end else if (FWFT == FWFT_ON) begin
            // Present the post-edge head; a write into a slot that becomes the
            // head this edge is forwarded from din since mem is not yet updated
            if (count_nxt == '0) begin
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= 1'b1;
                dout       <= (wr_acc && (wptr == rptr_nxt)) ? din : mem[rptr_nxt];
            end
        end else begin
            dout_valid <= rd_acc;
            if (rd_acc) begin
                dout <= mem[rptr];
            end
        end
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DWIDTH, default 16: data width in bits, legal range 1..256.
REQ-002 Parameter DEPTH, default 8: number of storage entries, legal range 2..1024, power of two not required.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts at or above this count.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts at or below this count.
REQ-005 Parameter FWFT, default 0: 0 selects a registered read, 1 selects first-word-fall-through.
REQ-006 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-008 Port clr, input, 1 bit: synchronous flush.
REQ-009 Port wr_en, input, 1 bit: write request.
REQ-010 Port din, input, DWIDTH bits: write data.
REQ-011 Port rd_en, input, 1 bit: read request, or pop in FWFT mode.
REQ-012 Port dout, output, DWIDTH bits: read data.
REQ-013 Port dout_valid, output, 1 bit: dout holds valid data.
REQ-014 Ports full, empty, almost_full and almost_empty, output, 1 bit each: status flags.
REQ-015 Port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-016 Ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-017 All DEPTH entries shall be usable: full = (count==DEPTH), empty = (count==0).
REQ-018 A write shall be accepted iff wr_en && !full; a read shall be accepted iff rd_en && !empty.
REQ-019 Simultaneous accepted read and write shall leave count unchanged.
REQ-020 Simultaneous read and write when empty shall accept only the write, so count becomes 1.
REQ-021 Simultaneous read and write when full shall accept only the read, so count becomes DEPTH-1.
REQ-022 Each pointer shall wrap from DEPTH-1 to 0 by explicit compare, never by modulo of a power of two.
REQ-023 count, full, empty, almost_full and almost_empty shall be registered and shall reflect accepted operations on the cycle after the edge.
REQ-024 FWFT=0: an accepted read shall load dout on the next edge (latency 1), dout_valid shall pulse high for that cycle, and dout shall otherwise hold its value.
REQ-025 FWFT=1: dout shall present the head entry whenever !empty, with dout_valid = !empty; rd_en shall pop the head, and the next entry shall appear the following cycle.
REQ-026 A write into an empty FIFO in FWFT mode shall become visible on dout one cycle after the write edge.
REQ-027 overflow shall set on wr_en && full, underflow shall set on rd_en && empty, and both shall hold until clr or rst.
REQ-028 clr shall zero the pointers, count and sticky flags and set dout_valid low, shall leave storage contents undefined, and shall take priority over wr_en and rd_en in the same cycle.
REQ-029 Storage shall not be reset.

Reset
REQ-030 rst shall asynchronously set wptr=0, rptr=0, count=0, dout=0, dout_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0 and underflow=0.
REQ-031 rst asserted mid-burst shall abort the burst; the first accepted write after deassertion shall be the first word read back.
REQ-032 No operation shall be accepted on the clock edge on which rst deasserts.

Structure
REQ-033 Package param_sync_fifo_pkg shall hold the default DWIDTH/DEPTH values, the count-width function, and the FWFT mode constants.
REQ-034 Sub-module fifo_wrap_ctr shall implement the DEPTH-modulo pointer with enable and sync clear, instantiated once for wptr and once for rptr.
REQ-035 The implementation shall contain no simulation-only $monitor or display code.

Verification
REQ-036 The bench shall cover: DEPTH=5, FWFT=0, write 5 words 0x0001..0x0005 -> full=1 and count=5; a 6th write -> overflow=1 and data unchanged; read 5 -> dout sequence 0x0001..0x0005 and empty=1.
REQ-037 The bench shall cover: DEPTH=5, write 3, then rd_en and wr_en together for 10 cycles -> count stays 3, data order preserved, and pointers wrap past 4 to 0 twice.
REQ-038 The bench shall cover: FWFT=1, a single write of 0xBEEF into an empty FIFO -> dout=0xBEEF and dout_valid=1 one cycle later; a pop -> empty=1 and dout_valid=0 next cycle.
REQ-039 The bench shall cover: AF_LEVEL=4 and AE_LEVEL=1 at DEPTH=5; fill from 0 to 5 -> almost_empty drops at count 2 and almost_full rises at count 4.
REQ-040 The bench shall cover: rd_en on an empty FIFO -> underflow=1 and count=0; clr -> underflow=0 and flags return to their reset values.
REQ-041 The bench shall cover: rst asserted asynchronously mid-cycle at count=3 -> all outputs reach their reset values before the next edge; a subsequent write and read return the new data.
